// File: rtl/mux4_rr_arbiter_if.sv
// Bundle between four 4-bit producers, the round-robin arbiter, and the single consumer.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] I0;
  logic [3:0] I1;
  logic [3:0] I2;
  logic [3:0] I3;
  logic [3:0] gnt;
  logic [1:0] s;
  logic [3:0] o;
  logic       o_valid;
  logic       busy;

  modport master (
    output req, I0, I1, I2, I3,
    input  gnt, s, o, o_valid, busy
  );

  modport slave (
    input  req, I0, I1, I2, I3,
    output gnt, s, o, o_valid, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4-bit 4:1 select datapath, with a per-grant hold
// timeout and registered select/data outputs.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input logic               clk,
  input logic               rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       s_q, s_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [3:0]       o_q, o_d;
  logic             ov_q, ov_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] pick_off;
  logic [1:0] pick;
  logic [3:0] sel_data;

  // Rotate requests so index 0 is the pointer, then take the lowest set bit.
  always_comb begin
    req_dbl = {bus.req, bus.req};
    req_rot = req_dbl[{1'b0, ptr_q} +: 4];
    if (req_rot[0])      pick_off = 2'd0;
    else if (req_rot[1]) pick_off = 2'd1;
    else if (req_rot[2]) pick_off = 2'd2;
    else                 pick_off = 2'd3;
    pick = ptr_q + pick_off;
  end

  always_comb begin
    case (s_q)
      2'd0:    sel_data = bus.I0;
      2'd1:    sel_data = bus.I1;
      2'd2:    sel_data = bus.I2;
      default: sel_data = bus.I3;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    o_d     = o_q;
    ov_d    = 1'b0;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (|bus.req) begin
          state_d = GRANT;
          s_d     = pick;
          gnt_d   = 4'b0001 << pick;
          hold_d  = '0;
        end
      end
      GRANT: begin
        o_d  = sel_data;
        ov_d = 1'b1;
        if (!bus.req[s_q] || (hold_q == HOLD_LAST)) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = s_q + 2'd1;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      s_q     <= 2'd0;
      gnt_q   <= 4'b0000;
      o_q     <= 4'h0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      o_q     <= o_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.s       = s_q;
  assign bus.o       = o_q;
  assign bus.o_valid = ov_q;
  assign bus.busy    = busy_q;

endmodule
